// File: rtl/cfg_param_bank_if.sv
// Host-side configuration bus: write port, read port and commit handshake.
// master = host driving requests, slave = the parameter bank answering them.
interface cfg_param_bank_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    // write channel
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    // commit handshake
    logic              commit_req;
    logic              commit_done;

    // read channel
    logic              rd_en;
    logic              rd_shadow;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    modport master (
        output wr_valid, wr_addr, wr_data,
        output commit_req,
        output rd_en, rd_shadow, rd_addr,
        input  wr_ready, commit_done,
        input  rd_data, rd_valid
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data,
        input  commit_req,
        input  rd_en, rd_shadow, rd_addr,
        output wr_ready, commit_done,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/cfg_param_bank.sv
// Configuration parameter bank: shadow + active copy per entry, atomic commit.
// Ports: clk, rst (async, active-high), bus (cfg_param_bank_if.slave:
//   write/read/commit), err_clr, active_flat (parallel active copy),
//   dirty (per-entry shadow-written flag), err (sticky), commit_cnt.
// The top NUM_LOCAL entries are read-only and stay at their reset value.
module cfg_param_bank #(
    parameter int NUM_ENTRIES = 8,
    parameter int DATA_W      = 32,
    parameter int NUM_LOCAL   = 2,
    parameter int ADDR_W      = $clog2(NUM_ENTRIES) + 1,
    parameter logic [NUM_ENTRIES*DATA_W-1:0] RESET_VAL = '0,
    parameter int CNT_W       = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    cfg_param_bank_if.slave               bus,
    input  logic                          err_clr,
    output logic [NUM_ENTRIES*DATA_W-1:0] active_flat,
    output logic [NUM_ENTRIES-1:0]        dirty,
    output logic                          err,
    output logic [CNT_W-1:0]              commit_cnt
);

    // Writable entries occupy indices 0 .. NUM_WR-1.
    localparam int NUM_WR = NUM_ENTRIES - NUM_LOCAL;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COPY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    logic [DATA_W-1:0] shadow [NUM_ENTRIES];
    logic [DATA_W-1:0] active [NUM_ENTRIES];

    logic              wr_fire;
    logic              wr_ok;
    logic              wr_bad;
    logic [DATA_W-1:0] rd_word;

    // wr_ready is registered and mirrors state==IDLE.
    assign wr_fire = bus.wr_valid && bus.wr_ready;
    assign wr_ok   = wr_fire && (bus.wr_addr < ADDR_W'(NUM_WR));
    assign wr_bad  = wr_fire && !wr_ok;

    // Read mux; unmatched (out-of-range) addresses fall through to zero.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (bus.rd_addr == ADDR_W'(i)) begin
                rd_word = bus.rd_shadow ? shadow[i] : active[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_flat
        assign active_flat[g*DATA_W +: DATA_W] = active[g];
    end

    // Commit FSM, storage arrays and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            bus.wr_ready    <= 1'b1;
            bus.commit_done <= 1'b0;
            commit_cnt      <= '0;
            dirty           <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                shadow[i] <= RESET_VAL[i*DATA_W +: DATA_W];
                active[i] <= RESET_VAL[i*DATA_W +: DATA_W];
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.commit_req) begin
                        state        <= COPY;
                        bus.wr_ready <= 1'b0;
                    end
                end
                COPY: begin
                    // Local entries are skipped; they never change.
                    for (int i = 0; i < NUM_WR; i++) begin
                        active[i] <= shadow[i];
                    end
                    dirty           <= '0;
                    state           <= DONE;
                    bus.commit_done <= 1'b1;
                    commit_cnt      <= commit_cnt + CNT_W'(1);
                end
                DONE: begin
                    state           <= IDLE;
                    bus.wr_ready    <= 1'b1;
                    bus.commit_done <= 1'b0;
                end
                default: begin
                    state           <= IDLE;
                    bus.wr_ready    <= 1'b1;
                    bus.commit_done <= 1'b0;
                end
            endcase

            // Writes only fire in IDLE, so they never race the COPY clear.
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_ok && (bus.wr_addr == ADDR_W'(i))) begin
                    shadow[i] <= bus.wr_data;
                    dirty[i]  <= 1'b1;
                end
            end
        end
    end

    // Sticky error: a new error in the same cycle beats err_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (wr_bad) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

    // Read port: samples pre-edge contents; rd_data holds when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
        end else begin
            bus.rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                bus.rd_data <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_cfg_param_bank.sv
// Directed table-driven bench for cfg_param_bank.
// Entry i resets to i*0x0101; 8 entries, 2 local, 2-bit commit counter.
module tb_cfg_param_bank;

    localparam int NE = 8;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam logic [NE*DW-1:0] RV = {
        32'h0707, 32'h0606, 32'h0505, 32'h0404,
        32'h0303, 32'h0202, 32'h0101, 32'h0000
    };

    typedef struct {
        logic          sh;
        logic [AW-1:0] addr;
        logic [DW-1:0] exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             err_clr = 1'b0;
    logic [NE*DW-1:0] active_flat;
    logic [NE-1:0]    dirty;
    logic             err;
    logic [1:0]       commit_cnt;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [1:0] exp_cnt = 2'd0;

    cfg_param_bank_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    cfg_param_bank #(
        .NUM_ENTRIES(NE),
        .DATA_W     (DW),
        .NUM_LOCAL  (2),
        .ADDR_W     (AW),
        .RESET_VAL  (RV),
        .CNT_W      (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .err_clr    (err_clr),
        .active_flat(active_flat),
        .dirty      (dirty),
        .err        (err),
        .commit_cnt (commit_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [NE*DW-1:0] act,
                         input logic [NE*DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic sh,
                          input logic [AW-1:0] a, input logic [DW-1:0] e);
        bus.rd_en     = 1'b1;
        bus.rd_shadow = sh;
        bus.rd_addr   = a;
        tick();
        bus.rd_en = 1'b0;
        check({nm, ".valid"}, bus.rd_valid, 1);
        check(nm, bus.rd_data, e);
    endtask

    // Pulses commit_req (optionally held into COPY) and checks the handshake.
    task automatic commit(input string nm, input logic hold);
        bus.commit_req = 1'b1;
        tick();
        bus.wr_valid = 1'b0;
        check({nm, ".copy_rdy"}, bus.wr_ready, 0);
        check({nm, ".copy_done"}, bus.commit_done, 0);
        bus.commit_req = hold;
        tick();
        bus.commit_req = 1'b0;
        exp_cnt = exp_cnt + 2'd1;
        check({nm, ".done_rdy"}, bus.wr_ready, 0);
        check({nm, ".done"}, bus.commit_done, 1);
        check({nm, ".cnt"}, commit_cnt, exp_cnt);
        tick();
        check({nm, ".idle_rdy"}, bus.wr_ready, 1);
        check({nm, ".idle_done"}, bus.commit_done, 0);
    endtask

    initial begin
        vec_t vecs[18];
        logic [1:0] seq[5];
        logic [NE*DW-1:0] exp_flat;

        for (int i = 0; i < NE; i++) begin
            vecs[2*i]   = '{1'b0, AW'(i), DW'(i) * 32'h0101};
            vecs[2*i+1] = '{1'b1, AW'(i), DW'(i) * 32'h0101};
        end
        vecs[16] = '{1'b0, 4'd8,  32'h0};
        vecs[17] = '{1'b1, 4'd15, 32'h0};
        seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        bus.wr_valid   = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.commit_req = 1'b0;
        bus.rd_en      = 1'b0;
        bus.rd_shadow  = 1'b0;
        bus.rd_addr    = '0;

        // 1: reset image
        tick();
        tick();
        #3 rst = 1'b0;
        tick();
        check("rst.rdy", bus.wr_ready, 1);
        check("rst.done", bus.commit_done, 0);
        check("rst.rvalid", bus.rd_valid, 0);
        check("rst.rdata", bus.rd_data, 0);
        check("rst.dirty", dirty, 0);
        check("rst.err", err, 0);
        check("rst.cnt", commit_cnt, 0);
        check("rst.flat", active_flat, RV);
        for (int k = 0; k < 18; k++) begin
            rd_chk($sformatf("t1.rd%0d", k), vecs[k].sh,
                   vecs[k].addr, vecs[k].exp);
            check($sformatf("t1.err%0d", k), err, 0);
        end
        rd_chk("t1.last", 1'b0, 4'd5, 32'h0505);
        tick();
        check("t1.idle_valid", bus.rd_valid, 0);
        check("t1.hold_data", bus.rd_data, 32'h0505);

        // 2: write then commit
        wr(4'd3, 32'hDEADBEEF);
        rd_chk("t2.act3", 1'b0, 4'd3, 32'h0303);
        rd_chk("t2.sh3", 1'b1, 4'd3, 32'hDEADBEEF);
        check("t2.dirty", dirty, 8'h08);
        check("t2.flat_pre", active_flat, RV);
        commit("t2", 1'b0);
        exp_flat = RV;
        exp_flat[3*DW +: DW] = 32'hDEADBEEF;
        check("t2.flat", active_flat, exp_flat);
        rd_chk("t2.act3b", 1'b0, 4'd3, 32'hDEADBEEF);
        check("t2.dirty0", dirty, 0);

        // 3: bad writes and sticky error
        wr(4'd6, 32'h55);
        check("t3.err_local", err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t3.clr1", err, 0);
        wr(4'd9, 32'h55);
        check("t3.err_oor", err, 1);
        check("t3.dirty", dirty, 0);
        rd_chk("t3.sh6", 1'b1, 4'd6, 32'h0606);
        err_clr = 1'b1;
        tick();
        check("t3.clr2", err, 0);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 4'd7;
        tick();
        bus.wr_valid = 1'b0;
        err_clr = 1'b0;
        check("t3.set_wins", err, 1);
        check("t3.flat", active_flat, exp_flat);

        // 4: write + commit same cycle; req during COPY ignored
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 4'd0;
        bus.wr_data  = 32'h11;
        commit("t4", 1'b1);
        rd_chk("t4.act0", 1'b0, 4'd0, 32'h11);
        check("t4.dirty", dirty, 0);
        check("t4.rdy_after", bus.wr_ready, 1);
        check("t4.cnt_once", commit_cnt, exp_cnt);

        // 6: async reset during COPY
        wr(4'd1, 32'hAA);
        wr(4'd7, 32'h0);
        check("t6.err_pre", err, 1);
        bus.commit_req = 1'b1;
        bus.rd_en      = 1'b1;
        bus.rd_shadow  = 1'b1;
        bus.rd_addr    = 4'd1;
        tick();
        bus.commit_req = 1'b0;
        bus.rd_en      = 1'b0;
        check("t6.in_copy", bus.wr_ready, 0);
        check("t6.rd_pre", bus.rd_data, 32'hAA);
        #2 rst = 1'b1;
        #1;
        check("t6.rdy", bus.wr_ready, 1);
        check("t6.done", bus.commit_done, 0);
        check("t6.rvalid", bus.rd_valid, 0);
        check("t6.rdata", bus.rd_data, 0);
        check("t6.dirty", dirty, 0);
        check("t6.err", err, 0);
        check("t6.cnt", commit_cnt, 0);
        check("t6.flat", active_flat, RV);
        exp_cnt = 2'd0;
        tick();
        #3 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("t6.nodone%0d", k), bus.commit_done, 0);
        end
        rd_chk("t6.act1", 1'b0, 4'd1, 32'h0101);
        rd_chk("t6.sh1", 1'b1, 4'd1, 32'h0101);

        // 5: counter wrap with CNT_W=2
        for (int k = 0; k < 5; k++) begin
            commit($sformatf("t5.c%0d", k), 1'b0);
            check($sformatf("t5.seq%0d", k), commit_cnt, seq[k]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
